// File: rtl/prng_sched_pkg.sv
// Shared types and helpers for the PRNG scheduler.
//   state_e     : sequencer states (IDLE, LOAD, WARMUP, SERVE)
//   DEFAULT_W   : default PRN/seed width
//   seed_fixup  : maps an all-zero seed to 1 so the PRNG never loads its lock-up value
package prng_sched_pkg;

    localparam int DEFAULT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WARMUP,
        SERVE
    } state_e;

    function automatic logic [31:0] seed_fixup(input logic [31:0] seed);
        return (seed == 32'd0) ? 32'd1 : seed;
    endfunction

endpackage

// File: rtl/prng_scheduler_rr_arbiter.sv
// Round-robin arbiter for the PRNG scheduler.
//   req_i     : request vector
//   ptr_i     : index where the search starts
//   en_i      : 0 forces no grant
//   gnt_o     : one-hot grant (all zero when nothing is granted)
//   ptr_nxt_o : index after the granted one, or ptr_i when nothing is granted
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PW-1:0]    ptr_nxt_o
);

    logic [PW-1:0] idx;
    logic          found;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        gnt_o     = '0;
        ptr_nxt_o = ptr_i;
        found     = 1'b0;
        idx       = '0;
        for (int off = 0; off < N_REQ; off++) begin
            idx = PW'((int'(ptr_i) + off) % N_REQ);
            if (en_i && !found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_nxt_o  = PW'((int'(idx) + 1) % N_REQ);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/prng_scheduler.sv
// PRNG scheduler: sequences an external PRNG (clear, seed load, warm-up, run) and
// hands each requester a unique PRN value per grant, advancing the PRNG once per grant.
// Reseeds with a stepped seed every RESEED_INTERVAL grants.
// Optional feature macro: LOCKUP_DETECT_EN (adds the LOCKUP port; a zero PRN seen
// while serving is never delivered and forces a reseed).
// Ports:
//   SYS_CLK, RST_N     : clock, asynchronous active-low reset
//   START              : level, 1 = run, 0 = back to IDLE
//   INIT_SEED          : seed for the first load after START rises
//   REQ / GNT          : requests (held until granted) / one-hot 1-cycle grant
//   RND_VALID/RND_DATA : PRN delivered alongside GNT
//   READY              : high in SERVE
//   PRNG_SCLR/LOAD/EN/SEED : controls to the PRNG; PRNG_PRN is its registered output
//   LOCKUP             : (LOCKUP_DETECT_EN only) sticky zero-PRN flag, cleared by IDLE
module prng_scheduler
    import prng_sched_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int W               = DEFAULT_W,
    parameter int WARMUP_CYCLES   = 16,
    parameter int RESEED_INTERVAL = 256,
    parameter int SEED_STEP       = 3
) (
    input  logic             SYS_CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [W-1:0]     INIT_SEED,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic             RND_VALID,
    output logic [W-1:0]     RND_DATA,
    output logic             READY,
    output logic             PRNG_SCLR,
    output logic             PRNG_LOAD,
    output logic             PRNG_EN,
    output logic [W-1:0]     PRNG_SEED,
    input  logic [W-1:0]     PRNG_PRN
`ifdef LOCKUP_DETECT_EN
    ,
    output logic             LOCKUP
`endif
);

    localparam int PW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GCW = $clog2(RESEED_INTERVAL + 1);
    localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;

    state_e           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [GCW-1:0]   gcnt_q, gcnt_d;
    logic [W-1:0]     seed_q, seed_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             valid_q, valid_d;
    logic [W-1:0]     data_q, data_d;
    logic             lockup_q, lockup_d;

    logic             lock_hit;
    logic             reseed_due;
    logic             serve_en;
    logic [N_REQ-1:0] arb_gnt;
    logic [PW-1:0]    arb_ptr;

`ifdef LOCKUP_DETECT_EN
    // A zero PRN means the PRNG is stuck; it takes the same path as an interval reseed.
    assign lock_hit = (state_q == SERVE) && (PRNG_PRN == '0);
    assign LOCKUP   = lockup_q;
`else
    assign lock_hit = 1'b0;
`endif

    // Once the interval is reached no further grant may consume a PRN from this seed.
    assign reseed_due = (gcnt_q == GCW'(RESEED_INTERVAL)) || lock_hit;
    assign serve_en   = (state_q == SERVE) && START && (|REQ) && !reseed_due;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_arb (
        .req_i     (REQ),
        .ptr_i     (ptr_q),
        .en_i      (serve_en),
        .gnt_o     (arb_gnt),
        .ptr_nxt_o (arb_ptr)
    );

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        gcnt_d   = gcnt_q;
        seed_d   = seed_q;
        ptr_d    = ptr_q;
        gnt_d    = '0;
        valid_d  = 1'b0;
        data_d   = data_q;
        lockup_d = START ? lockup_q : 1'b0;

        unique case (state_q)
            IDLE: begin
                gcnt_d = '0;
                if (START) begin
                    seed_d  = W'(seed_fixup(32'(INIT_SEED)));
                    state_d = LOAD;
                end
            end
            LOAD: begin
                wcnt_d  = '0;
                state_d = START ? WARMUP : IDLE;
            end
            WARMUP: begin
                if (!START) begin
                    state_d = IDLE;
                end else if (wcnt_q == WCW'(WARMUP_CYCLES - 1)) begin
                    state_d = SERVE;
                end else begin
                    wcnt_d = wcnt_q + WCW'(1);
                end
            end
            SERVE: begin
                if (!START) begin
                    state_d = IDLE;
                end else if (reseed_due) begin
                    state_d = LOAD;
                    seed_d  = W'(seed_fixup(32'(W'(seed_q + W'(SEED_STEP)))));
                    gcnt_d  = '0;
                    if (lock_hit) begin
                        lockup_d = 1'b1;
                    end
                end else if (|arb_gnt) begin
                    // PRNG_EN is high this cycle, so the PRN captured here is consumed.
                    gnt_d   = arb_gnt;
                    valid_d = 1'b1;
                    data_d  = PRNG_PRN;
                    ptr_d   = arb_ptr;
                    gcnt_d  = gcnt_q + GCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            gcnt_q   <= '0;
            seed_q   <= '0;
            ptr_q    <= '0;
            gnt_q    <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            gcnt_q   <= gcnt_d;
            seed_q   <= seed_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            lockup_q <= lockup_d;
        end
    end

    assign GNT       = gnt_q;
    assign RND_VALID = valid_q;
    assign RND_DATA  = data_q;
    assign READY     = (state_q == SERVE);
    assign PRNG_SCLR = (state_q == IDLE);
    assign PRNG_LOAD = (state_q == LOAD);
    assign PRNG_EN   = (state_q == WARMUP) || serve_en;
    assign PRNG_SEED = seed_q;

endmodule

// File: tb/tb_prng_scheduler.sv
// Self-checking bench for prng_scheduler with a small 10-bit LFSR standing in for the PRNG.
// Optional feature macro: LOCKUP_DETECT_EN (enables the lock-up scenario).
module tb_prng_scheduler;

    localparam int N  = 4;
    localparam int W  = 10;
    localparam int WU = 4;
    localparam int RI = 8;
    localparam int ST = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  init_seed;
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic          rnd_valid;
    logic [W-1:0]  rnd_data;
    logic          ready;
    logic          prng_sclr;
    logic          prng_load;
    logic          prng_en;
    logic [W-1:0]  prng_seed;
    logic [W-1:0]  prng_prn;
    logic [W-1:0]  prn_q = '0;
    logic          force_zero;
    logic          model_on;
`ifdef LOCKUP_DETECT_EN
    logic          lockup;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prng_scheduler #(
        .N_REQ           (N),
        .W               (W),
        .WARMUP_CYCLES   (WU),
        .RESEED_INTERVAL (RI),
        .SEED_STEP       (ST)
    ) dut (
        .SYS_CLK   (clk),
        .RST_N     (rst_n),
        .START     (start),
        .INIT_SEED (init_seed),
        .REQ       (req),
        .GNT       (gnt),
        .RND_VALID (rnd_valid),
        .RND_DATA  (rnd_data),
        .READY     (ready),
        .PRNG_SCLR (prng_sclr),
        .PRNG_LOAD (prng_load),
        .PRNG_EN   (prng_en),
        .PRNG_SEED (prng_seed),
        .PRNG_PRN  (prng_prn)
`ifdef LOCKUP_DETECT_EN
        ,
        .LOCKUP    (lockup)
`endif
    );

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] x);
        return {x[8:0], x[9] ^ x[6]};
    endfunction

    function automatic logic [W-1:0] fix(input logic [W-1:0] s);
        return (s == '0) ? W'(1) : s;
    endfunction

    // PRN owed to grant number g after a (re)start with seed s0.
    function automatic logic [W-1:0] model_prn(input logic [W-1:0] s0, input int g);
        logic [W-1:0] s = s0;
        for (int e = 0; e < g / RI; e++) s = fix(W'(s + W'(ST)));
        for (int n = 0; n < WU + (g % RI); n++) s = lfsr_next(s);
        return s;
    endfunction

    // PRNG stand-in: SCLR > LOAD > EN, output registered.
    always @(posedge clk) begin
        if (prng_sclr)      prn_q <= '0;
        else if (prng_load) prn_q <= prng_seed;
        else if (prng_en)   prn_q <= lfsr_next(prn_q);
    end
    assign prng_prn = force_zero ? '0 : prn_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    // Reference model: grant order from RR over sampled REQ, data from closed-form PRN index.
    logic [N-1:0] m_req;
    int           m_ptr = 0;
    int           m_g = 0;
    bit           m_run = 0;
    logic [W-1:0] m_seed0 = '0;
    int           m_idx;
    int           m_j;
    logic [N-1:0] m_exp;

    always begin
        @(posedge clk);
        if (!rst_n) begin
            m_ptr = 0;
            m_run = 0;
            m_g   = 0;
        end else if (!start) begin
            m_run = 0;
        end else if (!m_run) begin
            m_run   = 1;
            m_seed0 = fix(init_seed);
            m_g     = 0;
        end
        m_req = req;
        @(negedge clk);
        if (model_on) begin
            if (rnd_valid) begin
                m_idx = -1;
                for (int k = 0; k < N; k++) begin
                    m_j = (m_ptr + k) % N;
                    if (m_idx < 0 && m_req[m_j]) m_idx = m_j;
                end
                m_exp = (m_idx >= 0) ? N'(1 << m_idx) : '0;
                check("model_gnt", 32'(gnt), 32'(m_exp));
                check("model_data", 32'(rnd_data), 32'(model_prn(m_seed0, m_g)));
                if (m_idx >= 0) m_ptr = (m_idx + 1) % N;
                m_g++;
            end else begin
                check("model_no_gnt", 32'(gnt), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] exp_g [5];
        logic [W-1:0] exp_d [5];
        bit           hit;
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_d = '{10'd80, 10'd161, 10'd322, 10'd645, 10'd267};

        rst_n = 1'b0; start = 1'b0; req = '0; init_seed = 10'd5;
        force_zero = 1'b0; model_on = 1'b1;

        // Reset values
        repeat (3) next_cycle();
        check("rst_gnt", 32'(gnt), 0);
        check("rst_valid", 32'(rnd_valid), 0);
        check("rst_data", 32'(rnd_data), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_sclr", 32'(prng_sclr), 1);
        check("rst_load", 32'(prng_load), 0);
        check("rst_seed", 32'(prng_seed), 0);
        check("rst_en", 32'(prng_en), 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Bring-up: one LOAD cycle with seed 5, then WU enable cycles, then READY
        start = 1'b1;
        next_cycle();
        check("load_pulse", 32'(prng_load), 1);
        check("load_seed", 32'(prng_seed), 5);
        check("load_sclr", 32'(prng_sclr), 0);
        check("load_en", 32'(prng_en), 0);
        for (int i = 0; i < WU; i++) begin
            next_cycle();
            check("warmup_en", 32'(prng_en), 1);
            check("warmup_ready", 32'(ready), 0);
            check("warmup_load", 32'(prng_load), 0);
        end
        next_cycle();
        check("serve_ready", 32'(ready), 1);
        check("serve_idle_en", 32'(prng_en), 0);

        // Round-robin with all requests held; PRN values pinned by hand
        req = 4'b1111;
        #1 check("serve_req_en", 32'(prng_en), 1);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            check("rr_gnt", 32'(gnt), 32'(exp_g[i]));
            check("rr_data", 32'(rnd_data), 32'(exp_d[i]));
        end
        repeat (3) next_cycle();
        check("grant8_valid", 32'(rnd_valid), 1);
        check("reseed_due_en", 32'(prng_en), 0);

        // Reseed after the 8th grant: stepped seed, warm-up, grants resume from ptr 0
        next_cycle();
        check("reseed_load", 32'(prng_load), 1);
        check("reseed_seed", 32'(prng_seed), 8);
        check("reseed_no_valid", 32'(rnd_valid), 0);
        for (int i = 0; i < WU; i++) begin
            next_cycle();
            check("reseed_warmup_en", 32'(prng_en), 1);
            check("reseed_warmup_valid", 32'(rnd_valid), 0);
        end
        next_cycle();
        check("reseed_ready", 32'(ready), 1);
        next_cycle();
        check("resume_gnt", 32'(gnt), 1);
        check("resume_data", 32'(rnd_data), 32'(model_prn(10'd8, 0)));

        // Abort mid-SERVE
        req = 4'b0101;
        start = 1'b0;
        #1 check("abort_en", 32'(prng_en), 0);
        next_cycle();
        check("abort_gnt", 32'(gnt), 0);
        check("abort_valid", 32'(rnd_valid), 0);
        check("abort_sclr", 32'(prng_sclr), 1);
        check("abort_ready", 32'(ready), 0);

        // Seed wrap: 1021 + 3 wraps to 0, replaced by 1
        init_seed = 10'd1021;
        req = 4'b1111;
        start = 1'b1;
        next_cycle();
        check("wrap_load_seed", 32'(prng_seed), 1021);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            next_cycle();
            hit = prng_load;
        end
        check("wrap_reseed_seen", 32'(hit), 1);
        check("wrap_seed", 32'(prng_seed), 1);
        repeat (WU + 5) next_cycle();
        start = 1'b0;
        req = '0;
        next_cycle();

        // Asynchronous reset pulse mid-WARMUP
        init_seed = 10'd5;
        start = 1'b1;
        repeat (3) next_cycle();
        check("pulse_pre_en", 32'(prng_en), 1);
        rst_n = 1'b0;
        #1;
        check("pulse_en", 32'(prng_en), 0);
        check("pulse_sclr", 32'(prng_sclr), 1);
        check("pulse_load", 32'(prng_load), 0);
        check("pulse_ready", 32'(ready), 0);
        check("pulse_seed", 32'(prng_seed), 0);
        check("pulse_data", 32'(rnd_data), 0);
        check("pulse_valid", 32'(rnd_valid), 0);
        start = 1'b0;
        next_cycle();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

`ifdef LOCKUP_DETECT_EN
        // Forced zero PRN in SERVE: no delivery, stepped reseed, sticky LOCKUP
        model_on = 1'b0;
        start = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            next_cycle();
            hit = ready;
        end
        check("lock_ready_seen", 32'(hit), 1);
        force_zero = 1'b1;
        req = 4'b1111;
        #1 check("lock_en", 32'(prng_en), 0);
        next_cycle();
        check("lock_valid", 32'(rnd_valid), 0);
        check("lock_load", 32'(prng_load), 1);
        check("lock_seed", 32'(prng_seed), 8);
        check("lock_flag", 32'(lockup), 1);
        force_zero = 1'b0;
        repeat (WU + 3) next_cycle();
        check("lock_sticky", 32'(lockup), 1);
        start = 1'b0;
        req = '0;
        next_cycle();
        check("lock_clear", 32'(lockup), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
